cdv_reset_seq: RTL and testbench

- Clock-divider reset sequencer for the DAQ optical TX path.
- Consumes CDV_INIT from the DAQ rate-select FSM and drives the word-clock divider's reset.
- Returns CDV_DONE once the divider has relocked and settled; the rate-select FSM holds in its RstClkDiv states until CDV_DONE is seen.
- Bounds lock waits with a timeout, retries the reset a limited number of times, then flags a failure.

---
 rtl/cdv_reset_seq.sv | 157 +++++++++++++++
 tb/tb_cdv_reset_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cdv_reset_seq.sv
// cdv_reset_seq: word-clock divider reset sequencer.
// Holds the divider in reset, waits for lock, settles, retries on timeout.
module cdv_reset_seq #(
  parameter int RST_CYCLES     = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRY      = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CDV_INIT,
  input  logic       CDV_LOCKED,
  output logic       CDV_RST,
  output logic       CDV_DONE,
  output logic       CDV_FAIL,
  output logic [2:0] RETRY_CNT,
  output logic [2:0] CDV_STATE
);

  localparam int CMAX_A =
    (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CMAX =
    (CMAX_A > TIMEOUT_CYCLES) ? CMAX_A : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STL_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    RTY_MAX  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_MINRST = 3'd1,
    S_WAIT   = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [2:0]      retry_d;
  logic            rst_d;
  logic            done_d;
  logic            fail_d;
  logic            lock_m;
  logic            lock_s;

  // Lock comes from the divider's clock domain.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= CDV_LOCKED;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = RETRY_CNT;
    if (CDV_INIT) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          cnt_d   = '0;
          retry_d = '0;
          state_d = S_MINRST;
        end
        S_MINRST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (lock_s) begin
            state_d = S_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (RETRY_CNT < RTY_MAX) begin
              retry_d = RETRY_CNT + 3'd1;
              state_d = S_MINRST;
            end else begin
              state_d = S_FAIL;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_SETTLE: begin
          if (!lock_s) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == STL_LAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: cnt_d = '0;
        S_FAIL: cnt_d = '0;
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the state being entered, then registered.
  always_comb begin
    rst_d  = 1'b0;
    done_d = 1'b0;
    fail_d = 1'b0;
    unique case (1'b1)
      (state_d == S_HOLD),
      (state_d == S_MINRST): rst_d  = 1'b1;
      (state_d == S_DONE):   done_d = 1'b1;
      (state_d == S_FAIL):   fail_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      RETRY_CNT <= '0;
      CDV_RST   <= 1'b1;
      CDV_DONE  <= 1'b0;
      CDV_FAIL  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      RETRY_CNT <= retry_d;
      CDV_RST   <= rst_d;
      CDV_DONE  <= done_d;
      CDV_FAIL  <= fail_d;
    end
  end

  assign CDV_STATE = state_q;

endmodule

// File: tb/tb_cdv_reset_seq.sv
// tb_cdv_reset_seq: directed bench for the divider reset sequencer.
// Linear steps with hand-computed cycle counts.
module tb_cdv_reset_seq;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CDV_INIT;
  logic       CDV_LOCKED;
  logic       CDV_RST;
  logic       CDV_DONE;
  logic       CDV_FAIL;
  logic [2:0] RETRY_CNT;
  logic [2:0] CDV_STATE;

  int total = 0;
  int bad   = 0;
  int n;
  int rh;

  cdv_reset_seq dut (
    .CLK        (CLK),
    .RST        (RST),
    .CDV_INIT   (CDV_INIT),
    .CDV_LOCKED (CDV_LOCKED),
    .CDV_RST    (CDV_RST),
    .CDV_DONE   (CDV_DONE),
    .CDV_FAIL   (CDV_FAIL),
    .RETRY_CNT  (RETRY_CNT),
    .CDV_STATE  (CDV_STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int lim,
                            output int cnt);
    cnt = 0;
    while (CDV_STATE != s && cnt < lim) begin
      tick(1);
      cnt++;
    end
  endtask

  task automatic count_state(input logic [2:0] s, input int lim,
                             output int cnt);
    cnt = 0;
    while (CDV_STATE == s && cnt < lim) begin
      tick(1);
      cnt++;
    end
  endtask

  initial begin
    RST        = 1'b0;
    CDV_INIT   = 1'b0;
    CDV_LOCKED = 1'b0;

    tick(3);
    chk("rst_state", CDV_STATE, 3'd0);
    chk("rst_cdvrst", CDV_RST, 1'b1);
    chk("rst_done", CDV_DONE, 1'b0);
    chk("rst_fail", CDV_FAIL, 1'b0);
    chk("rst_retry", RETRY_CNT, 3'd0);
    RST = 1'b1;
    tick(1);
    chk("rel_minrst", CDV_STATE, 3'd1);
    count_state(3'd1, 20, n);
    chk("rel_minrst_len", n, 8);
    chk("rel_wait", CDV_STATE, 3'd2);
    chk("rel_wait_rst", CDV_RST, 1'b0);

    CDV_LOCKED = 1'b1;
    CDV_INIT   = 1'b1;
    tick(5);
    chk("nom_hold", CDV_STATE, 3'd0);
    chk("nom_hold_rst", CDV_RST, 1'b1);
    chk("nom_hold_done", CDV_DONE, 1'b0);
    CDV_INIT = 1'b0;
    n  = 0;
    rh = 0;
    while (!CDV_DONE && n < 60) begin
      tick(1);
      n++;
      if (CDV_RST) rh++;
    end
    chk("nom_latency_ok", (n >= 26 && n <= 28), 1'b1);
    chk("nom_rst_len", rh, 8);
    tick(10);
    chk("nom_done_hold", CDV_DONE, 1'b1);
    chk("nom_state_done", CDV_STATE, 3'd4);
    CDV_LOCKED = 1'b0;
    tick(4);
    chk("nom_done_nolock", CDV_DONE, 1'b1);
    CDV_INIT = 1'b1;
    tick(1);
    chk("nom_reinit_state", CDV_STATE, 3'd0);
    chk("nom_reinit_done", CDV_DONE, 1'b0);
    chk("nom_reinit_rst", CDV_RST, 1'b1);

    CDV_LOCKED = 1'b1;
    tick(1);
    CDV_INIT = 1'b0;
    wait_state(3'd3, 60, n);
    chk("gl_settle", CDV_STATE, 3'd3);
    tick(10);
    CDV_LOCKED = 1'b0;
    tick(1);
    CDV_LOCKED = 1'b1;
    wait_state(3'd2, 10, n);
    chk("gl_back_wait_n", n, 2);
    chk("gl_back_wait", CDV_STATE, 3'd2);
    chk("gl_retry", RETRY_CNT, 3'd0);
    chk("gl_done0", CDV_DONE, 1'b0);
    wait_state(3'd3, 10, n);
    chk("gl_resettle_n", n, 1);
    count_state(3'd3, 40, n);
    chk("gl_settle_len", n, 16);
    chk("gl_done", CDV_DONE, 1'b1);

    CDV_INIT   = 1'b1;
    CDV_LOCKED = 1'b0;
    tick(2);
    CDV_INIT = 1'b0;
    for (int a = 0; a < 4; a++) begin
      wait_state(3'd2, 40, n);
      count_state(3'd2, 1100, n);
      chk("to_wait_len", n, 1024);
      chk("to_done0", CDV_DONE, 1'b0);
      if (a < 3) begin
        chk("to_minrst", CDV_STATE, 3'd1);
        chk("to_retry", RETRY_CNT, 3'(a + 1));
        chk("to_rst_hi", CDV_RST, 1'b1);
        count_state(3'd1, 20, n);
        chk("to_pulse_len", n, 8);
      end else begin
        chk("to_fail_state", CDV_STATE, 3'd5);
        chk("to_fail", CDV_FAIL, 1'b1);
        chk("to_fail_retry", RETRY_CNT, 3'd3);
        chk("to_fail_rst", CDV_RST, 1'b0);
      end
    end
    tick(5);
    chk("fail_sticky", CDV_FAIL, 1'b1);
    chk("fail_sticky_st", CDV_STATE, 3'd5);

    CDV_LOCKED = 1'b1;
    CDV_INIT   = 1'b1;
    tick(1);
    chk("rec_hold", CDV_STATE, 3'd0);
    chk("rec_fail0", CDV_FAIL, 1'b0);
    chk("rec_retry0", RETRY_CNT, 3'd0);
    chk("rec_rst", CDV_RST, 1'b1);
    tick(1);
    CDV_INIT = 1'b0;
    n = 0;
    while (!CDV_DONE && n < 60) begin
      tick(1);
      n++;
    end
    chk("rec_latency_ok", (n >= 26 && n <= 28), 1'b1);
    chk("rec_fail_low", CDV_FAIL, 1'b0);

    CDV_INIT = 1'b1;
    tick(1);
    CDV_INIT = 1'b0;
    wait_state(3'd3, 60, n);
    tick(15);
    chk("sim_settle15", CDV_STATE, 3'd3);
    chk("sim_done0a", CDV_DONE, 1'b0);
    CDV_INIT = 1'b1;
    tick(1);
    chk("sim_hold", CDV_STATE, 3'd0);
    chk("sim_done0b", CDV_DONE, 1'b0);
    chk("sim_rst", CDV_RST, 1'b1);

    CDV_LOCKED = 1'b0;
    tick(1);
    CDV_INIT = 1'b0;
    n = 0;
    while (!(RETRY_CNT == 3'd1 && CDV_STATE == 3'd2) && n < 1200) begin
      tick(1);
      n++;
    end
    chk("rw_retry1", RETRY_CNT, 3'd1);
    chk("rw_wait", CDV_STATE, 3'd2);
    tick(3);
    RST = 1'b0;
    tick(1);
    chk("rw_state", CDV_STATE, 3'd0);
    chk("rw_cdvrst", CDV_RST, 1'b1);
    chk("rw_done", CDV_DONE, 1'b0);
    chk("rw_fail", CDV_FAIL, 1'b0);
    chk("rw_retry0", RETRY_CNT, 3'd0);
    RST = 1'b1;
    tick(1);
    chk("rw_minrst", CDV_STATE, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
